// File: rtl/branch_resolution_unit.sv
// Branch resolution with a saturating-counter BHT, a registered PC redirect on
// mispredict, a multi-cycle flush sequencer and saturating branch statistics.
module branch_resolution_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int BHT_DEPTH    = 64,
    parameter int COUNTER_BITS = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  predict_taken,
    input  logic                  resolve_valid,
    input  logic                  branch,
    input  logic                  jump,
    input  logic [2:0]            func_3_bits,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  zero,
    input  logic [ADDR_WIDTH-1:0] mem_pc,
    input  logic [ADDR_WIDTH-1:0] target_in,
    input  logic                  predicted_taken_in,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush,
    output logic                  illegal_branch,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int FCW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int CNT_INIT_I = (1 << (COUNTER_BITS - 1)) - 1;
    localparam logic [COUNTER_BITS-1:0] CNT_INIT = COUNTER_BITS'(CNT_INIT_I);
    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t                  r_state, w_state_next;
    logic [FCW-1:0]          r_flush_cnt, w_flush_cnt_next;
    logic [COUNTER_BITS-1:0] r_bht [BHT_DEPTH];
    logic                    r_redirect_valid, r_illegal;
    logic [ADDR_WIDTH-1:0]   r_redirect_pc;
    logic [31:0]             r_branch_count, r_mispredict_count;

    logic                    w_taken, w_illegal, w_accept, w_mispredict, w_bht_we;
    logic [IDX_W-1:0]        w_lookup_idx, w_upd_idx;
    logic [COUNTER_BITS-1:0] w_upd_cur, w_upd_next;
    logic                    w_unused;

    assign w_unused     = ^{if_pc, mem_pc, alu_result};
    assign w_lookup_idx = if_pc[IDX_W+1:2];
    assign w_upd_idx    = mem_pc[IDX_W+1:2];
    assign predict_taken = r_bht[w_lookup_idx][COUNTER_BITS-1];

    // Jump overrides branch; reserved funct3 codes resolve not-taken and flag illegal.
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        if (jump) begin
            w_taken = 1'b1;
        end else if (branch) begin
            case (func_3_bits)
                3'b000:         w_taken = zero;
                3'b001:         w_taken = !zero;
                3'b100, 3'b110: w_taken = alu_result[0];
                3'b101, 3'b111: w_taken = !alu_result[0];
                default:        w_illegal = 1'b1;
            endcase
        end
    end

    assign w_accept     = resolve_valid && (r_state == S_IDLE);
    assign w_mispredict = w_accept && (jump || (w_taken != predicted_taken_in));
    assign w_bht_we     = w_accept && branch && !jump;
    assign w_upd_cur    = r_bht[w_upd_idx];

    always_comb begin
        w_upd_next = w_upd_cur;
        if (w_taken) begin
            if (w_upd_cur != CNT_MAX) w_upd_next = w_upd_cur + 1'b1;
        end else begin
            if (w_upd_cur != '0) w_upd_next = w_upd_cur - 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            always_ff @(posedge CLK) begin
                if (RESET)
                    r_bht[gi] <= CNT_INIT;
                else if (w_bht_we && (w_upd_idx == IDX_W'(gi)))
                    r_bht[gi] <= w_upd_next;
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_mispredict) begin
                    w_state_next     = S_FLUSH;
                    w_flush_cnt_next = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == '0) w_state_next = S_IDLE;
                else                   w_flush_cnt_next = r_flush_cnt - 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_redirect_valid   <= 1'b0;
            r_redirect_pc      <= '0;
            r_illegal          <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_redirect_valid <= w_mispredict;
            r_illegal        <= w_accept && w_illegal;
            if (w_mispredict) begin
                r_redirect_pc <= w_taken ? target_in : mem_pc + ADDR_WIDTH'(4);
                if (r_mispredict_count != 32'hFFFF_FFFF)
                    r_mispredict_count <= r_mispredict_count + 32'd1;
            end
            if (w_accept && (r_branch_count != 32'hFFFF_FFFF))
                r_branch_count <= r_branch_count + 32'd1;
        end
    end

    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign flush            = (r_state == S_FLUSH);
    assign illegal_branch   = r_illegal;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
endmodule
